// File: rtl/demux_dest_pkg.sv
// Shared types for the destination demultiplexer: word geometry, destination codes
// and FSM encodings.
package demux_dest_pkg;

  localparam int BITNUMBER_DEF = 6;
  localparam int DEST_W        = 2;
  localparam int N_DEST        = 4;

  typedef enum logic [DEST_W-1:0] {
    DEST0 = 2'b00,
    DEST1 = 2'b01,
    DEST2 = 2'b10,
    DEST3 = 2'b11
  } dest_e;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  function automatic logic [N_DEST-1:0] dest_onehot(input dest_e d);
    logic [N_DEST-1:0] oh;
    oh = '0;
    case (d)
      DEST0:   oh = 4'b0001;
      DEST1:   oh = 4'b0010;
      DEST2:   oh = 4'b0100;
      DEST3:   oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_dest_dest_counter.sv
// Per-destination delivered-word counter; wraps modulo 2^CNT_WIDTH, clear wins over inc.
module dest_counter #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux_dest.sv
// Pops the upstream data FIFO and routes each word to one of four destination FIFOs
// selected by the word's two MSBs.
//
//   state  | meaning
//   INIT   | after reset or init; no pops
//   IDLE   | upstream empty, waiting for data
//   ACTIVE | popping whenever upstream has data and nothing is paused
module demux_dest
  import demux_dest_pkg::*;
#(
  parameter int BITNUMBER = BITNUMBER_DEF,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 Fifo_empty,
  input  logic [BITNUMBER-1:0] Fifo_Data_out,
  input  logic                 valid_read,
  output logic                 Fifo_rd,
  input  logic                 pause_0,
  input  logic                 pause_1,
  input  logic                 pause_2,
  input  logic                 pause_3,
  output logic                 push_0,
  output logic                 push_1,
  output logic                 push_2,
  output logic                 push_3,
  output logic [BITNUMBER-1:0] data_out_0,
  output logic [BITNUMBER-1:0] data_out_1,
  output logic [BITNUMBER-1:0] data_out_2,
  output logic [BITNUMBER-1:0] data_out_3,
  output logic [CNT_WIDTH-1:0] cnt_0,
  output logic [CNT_WIDTH-1:0] cnt_1,
  output logic [CNT_WIDTH-1:0] cnt_2,
  output logic [CNT_WIDTH-1:0] cnt_3,
  output logic                 idle,
  output logic                 protocol_error
);

  state_e               state_q, state_d;
  logic                 inflight_q;
  logic                 idle_q, idle_d;
  logic                 err_q, err_d;
  logic [N_DEST-1:0]    push_q, push_d;
  logic [BITNUMBER-1:0] data_q [N_DEST];
  logic [CNT_WIDTH-1:0] cnt_w  [N_DEST];
  logic                 stall;
  logic                 deliver;
  dest_e                dest;

  // The destination is unknown until data returns, so any pause stalls all pops.
  assign stall   = pause_0 | pause_1 | pause_2 | pause_3;
  assign Fifo_rd = (state_q == ACTIVE) & ~Fifo_empty & ~stall;
  assign dest    = dest_e'(Fifo_Data_out[BITNUMBER-1 -: DEST_W]);
  assign deliver = valid_read & inflight_q & ~init;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = INIT;
    end else begin
      case (state_q)
        INIT:    state_d = IDLE;
        IDLE:    if (!Fifo_empty) state_d = ACTIVE;
        ACTIVE:  if (Fifo_empty && !inflight_q) state_d = IDLE;
        default: state_d = INIT;
      endcase
    end
  end

  always_comb begin
    push_d = deliver ? dest_onehot(dest) : '0;
    idle_d = (state_q == IDLE) & ~inflight_q;
    err_d  = init ? 1'b0 : (err_q | (valid_read & ~inflight_q));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      push_q     <= '0;
      idle_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < N_DEST; i++) data_q[i] <= '0;
    end else begin
      inflight_q <= Fifo_rd;
      push_q     <= push_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
      for (int i = 0; i < N_DEST; i++)
        if (push_d[i]) data_q[i] <= Fifo_Data_out;
    end
  end

  for (genvar g = 0; g < N_DEST; g++) begin : g_cnt
    dest_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (init),
      .inc_i (push_d[g]),
      .cnt_o (cnt_w[g])
    );
  end

  assign push_0         = push_q[0];
  assign push_1         = push_q[1];
  assign push_2         = push_q[2];
  assign push_3         = push_q[3];
  assign data_out_0     = data_q[0];
  assign data_out_1     = data_q[1];
  assign data_out_2     = data_q[2];
  assign data_out_3     = data_q[3];
  assign cnt_0          = cnt_w[0];
  assign cnt_1          = cnt_w[1];
  assign cnt_2          = cnt_w[2];
  assign cnt_3          = cnt_w[3];
  assign idle           = idle_q;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_demux_dest.sv
// Scoreboard bench for demux_dest: an upstream FIFO model feeds words, expected
// deliveries are queued at pop time and compared when the pushes appear.
module tb_demux_dest;

  localparam int BN = 6;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, init, Fifo_empty, valid_read;
  logic [BN-1:0] Fifo_Data_out;
  logic          Fifo_rd;
  logic          pause_0, pause_1, pause_2, pause_3;
  logic          push_0, push_1, push_2, push_3;
  logic [BN-1:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic [CW-1:0] cnt_0, cnt_1, cnt_2, cnt_3;
  logic          idle, protocol_error;

  demux_dest #(.BITNUMBER(BN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .init(init), .Fifo_empty(Fifo_empty),
    .Fifo_Data_out(Fifo_Data_out), .valid_read(valid_read), .Fifo_rd(Fifo_rd),
    .pause_0(pause_0), .pause_1(pause_1), .pause_2(pause_2), .pause_3(pause_3),
    .push_0(push_0), .push_1(push_1), .push_2(push_2), .push_3(push_3),
    .data_out_0(data_out_0), .data_out_1(data_out_1),
    .data_out_2(data_out_2), .data_out_3(data_out_3),
    .cnt_0(cnt_0), .cnt_1(cnt_1), .cnt_2(cnt_2), .cnt_3(cnt_3),
    .idle(idle), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  logic [BN-1:0] dout  [4];
  logic [CW-1:0] cnt_v [4];
  logic [3:0]    push_v;
  assign dout[0] = data_out_0;  assign dout[1] = data_out_1;
  assign dout[2] = data_out_2;  assign dout[3] = data_out_3;
  assign cnt_v[0] = cnt_0;      assign cnt_v[1] = cnt_1;
  assign cnt_v[2] = cnt_2;      assign cnt_v[3] = cnt_3;
  assign push_v  = {push_3, push_2, push_1, push_0};

  typedef struct {
    logic [BN-1:0] word;
    int            due;
  } exp_t;

  exp_t          exp_q [$];
  logic [BN-1:0] up_q  [$];
  logic [CW-1:0] cnt_m [4];
  logic [BN-1:0] data_m[4];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  bit            pend, last_rd, saw255;
  logic [BN-1:0] pend_word;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic load(input logic [BN-1:0] w);
    up_q.push_back(w);
    Fifo_empty = 1'b0;
  endtask

  task automatic flush_model();
    exp_q.delete();
    pend       = 1'b0;
    valid_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt_m[i]  = '0;
      data_m[i] = '0;
    end
  endtask

  // One clock: sample pop at negedge, then after the edge drive returned data and
  // compare pushes, held data and counters against the model.
  task automatic cycle();
    exp_t       e;
    logic [3:0] exp_push;
    int         d;
    @(negedge clk);
    last_rd = Fifo_rd;
    pend    = 1'b0;
    if (Fifo_rd) begin
      if (up_q.size() == 0) begin
        check_val("rd_when_empty", {31'd0, Fifo_rd}, 32'd0);
      end else begin
        pend_word = up_q.pop_front();
        pend      = 1'b1;
        exp_q.push_back('{pend_word, cyc + 2});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    valid_read    = pend;
    Fifo_Data_out = pend_word;
    Fifo_empty    = (up_q.size() == 0);
    while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
    exp_push = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      d = int'(e.word[BN-1 -: 2]);
      exp_push[d] = 1'b1;
      data_m[d]   = e.word;
      cnt_m[d]    = cnt_m[d] + 1'b1;
    end
    check_val("push", {28'd0, push_v}, {28'd0, exp_push});
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("data_out_%0d", i), {26'd0, dout[i]}, {26'd0, data_m[i]});
      check_val($sformatf("cnt_%0d", i), {24'd0, cnt_v[i]}, {24'd0, cnt_m[i]});
    end
  endtask

  task automatic wait_rd(input string tag);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_rd && n < 10);
    check_val(tag, {31'd0, last_rd}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; init = 1'b0; Fifo_empty = 1'b1; valid_read = 1'b0;
    Fifo_Data_out = '0; pend_word = '0;
    pause_0 = 1'b0; pause_1 = 1'b0; pause_2 = 1'b0; pause_3 = 1'b0;
    flush_model();

    // Reset, then INIT -> IDLE
    repeat (2) cycle();
    check_val("rst_idle", {31'd0, idle}, 32'd0);
    check_val("rst_err", {31'd0, protocol_error}, 32'd0);
    reset = 1'b1;
    cycle();
    check_val("idle_lag", {31'd0, idle}, 32'd0);
    cycle();
    check_val("idle_up", {31'd0, idle}, 32'd1);
    check_val("idle_rd", {31'd0, Fifo_rd}, 32'd0);

    // Routing, back-to-back pops
    load(6'b00_0101); load(6'b01_1010); load(6'b10_0011); load(6'b11_1111);
    wait_rd("route_rd_start");
    for (int j = 1; j < 4; j++) begin
      cycle();
      check_val("route_rd_b2b", {31'd0, last_rd}, 32'd1);
    end
    cycle();
    check_val("route_rd_stop", {31'd0, last_rd}, 32'd0);
    repeat (4) cycle();
    check_val("route_cnt0", {24'd0, cnt_0}, 32'd1);
    check_val("route_cnt1", {24'd0, cnt_1}, 32'd1);
    check_val("route_cnt2", {24'd0, cnt_2}, 32'd1);
    check_val("route_cnt3", {24'd0, cnt_3}, 32'd1);

    // Back-pressure with one word in flight
    load(6'b10_0001); load(6'b10_0010); load(6'b01_0111);
    wait_rd("bp_first_pop");
    pause_2 = 1'b1;
    repeat (5) begin
      cycle();
      check_val("rd_paused", {31'd0, last_rd}, 32'd0);
    end
    check_val("inflight_delivered", {24'd0, cnt_2}, 32'd2);
    pause_2 = 1'b0;
    cycle();
    check_val("rd_resume", {31'd0, last_rd}, 32'd1);
    repeat (6) cycle();

    // Pause raised together with data arriving
    pause_0 = 1'b1;
    load(6'b00_1100);
    repeat (3) begin
      cycle();
      check_val("rd_paused_arrival", {31'd0, last_rd}, 32'd0);
    end
    pause_0 = 1'b0;
    cycle();
    check_val("rd_after_unpause", {31'd0, last_rd}, 32'd1);
    repeat (5) cycle();

    // Protocol error, then init clears it and the counters
    valid_read    = 1'b1;
    Fifo_Data_out = 6'b11_0000;
    cycle();
    check_val("proto_err", {31'd0, protocol_error}, 32'd1);
    cycle();
    check_val("proto_err_sticky", {31'd0, protocol_error}, 32'd1);
    init = 1'b1;
    for (int i = 0; i < 4; i++) cnt_m[i] = '0;
    cycle();
    init = 1'b0;
    check_val("init_clr_err", {31'd0, protocol_error}, 32'd0);
    cycle();
    check_val("init_state", {31'd0, idle}, 32'd0);
    cycle();
    check_val("init_to_idle", {31'd0, idle}, 32'd1);

    // Counter wrap on destination 1
    for (int k = 0; k < 256; k++) load({2'b01, 4'($urandom_range(0, 15))});
    saw255 = 1'b0;
    n = 0;
    while ((up_q.size() != 0 || exp_q.size() != 0) && n < 600) begin
      cycle();
      if (cnt_1 == 8'd255) saw255 = 1'b1;
      n++;
    end
    check_val("wrap_drained", up_q.size() + exp_q.size(), 32'd0);
    check_val("cnt1_hit_255", {31'd0, saw255}, 32'd1);
    check_val("cnt1_wrapped", {24'd0, cnt_1}, 32'd0);
    check_val("wrap_cnt0", {24'd0, cnt_0}, 32'd0);
    check_val("wrap_cnt3", {24'd0, cnt_3}, 32'd0);
    repeat (3) cycle();

    // Asynchronous reset with a read in flight
    load(6'b11_0110);
    wait_rd("mid_rst_pop");
    reset = 1'b0;
    #1;
    check_val("arst_rd", {31'd0, Fifo_rd}, 32'd0);
    check_val("arst_push", {28'd0, push_v}, 32'd0);
    check_val("arst_data1", {26'd0, data_out_1}, 32'd0);
    check_val("arst_idle", {31'd0, idle}, 32'd0);
    check_val("arst_err", {31'd0, protocol_error}, 32'd0);
    flush_model();
    repeat (2) cycle();
    reset = 1'b1;
    repeat (4) cycle();
    check_val("no_push_after_rst", {24'd0, cnt_3}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
